mdu_hilo: RTL
=============

// Module: mdu_hilo
// PURPOSE
//  Multiply/divide unit with HI/LO registers; E-stage responder to the decoder's
//  start / hilowe / hilo_A3 / re_hi_loop controls. Runs multi-cycle mult/multu/div/divu.
//  Exposes busy, which the hazard unit combines with stall_busy to freeze D.
//  Serves mthi/mtlo writes and the mfhi/mflo read mux.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu
//  DIV_CYCLES   10  busy cycles for div/divu
// PORTS
//  clk         in   1   clock; single clock domain
//  reset       in   1   asynchronous, active-high; clears all state
//  start       in   1   E-stage instr is mult/multu/div/divu
//  md_op       in   2   00 mult, 01 multu, 10 div, 11 divu (from ALUop)
//  A           in   32  rs operand (forwarded)
//  B           in   32  rt operand (forwarded)
//  hilowe      in   1   mthi/mtlo write enable
//  hilo_A3     in   1   write target: 0 = HI, 1 = LO
//  req         in   1   exception/interrupt flush of E-stage instr this cycle
//  re_hi_loop  in   2   read select: 01 HI, 10 LO, else 0
//  busy        out  1   operation in progress
//  hilo_out    out  32  read data to E/M pipeline for mfhi/mflo
// BEHAVIOUR
//  Reset: HI=0, LO=0, busy=0, cnt=0, latched operands 0; hilo_out=0 unless
//   re_hi_loop selects a register (then HI/LO = 0).
//  States: IDLE (busy=0), RUN (busy=1, cnt counts down).
//  IDLE + start & !req at edge T: latch A, B, md_op; cnt <= N (MULT_CYCLES or
//   DIV_CYCLES); go RUN. busy is 1 from T+1 through T+N inclusive.
//  RUN: cnt decrements each edge. At the edge where cnt==1: write HI/LO,
//   busy drops, back to IDLE. New HI/LO is visible the cycle busy is 0.
//  Hazard unit stalls D on start|busy; start while busy cannot occur and is ignored.
//  req does not cancel an op already in RUN; it suppresses a same-cycle start
//   and a same-cycle hilowe (the flushed instr has no effect).
//  hilowe & !req & !busy: HI or LO <= A at the edge. hilowe while busy is ignored.
//  Arithmetic (32-bit in, registers 32-bit):
//   mult  {HI,LO} = $signed(A)*$signed(B), 64-bit
//   multu {HI,LO} = A*B unsigned, 64-bit
//   div   LO = quotient truncated toward zero, HI = remainder (sign of dividend)
//   divu  LO = A/B, HI = A%B unsigned
//   divide by zero (B==0): op still takes DIV_CYCLES; HI/LO unchanged
//   div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0
//  Result is computed from latched operands; A/B changes during RUN have no effect.
//  Read path is combinational: hilo_out = HI/LO per re_hi_loop, else 0.
//   A read during busy cannot occur because of the stall.
//  Reset asserted mid-RUN: immediate abort to IDLE; HI/LO = 0; no completion write.
// STRUCTURE
//  define.v constants:
//   md_op codes: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
//   read selects: RE_HI = 2'b01, RE_LO = 2'b10
//  No sub-module: one counter, operand latches, combinational result, HI/LO regs.
// TESTING
//  1. mult 0xFFFFFFFE * 3 (signed), start=1 one cycle -> busy 5 cycles;
//     then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. multu 0xFFFFFFFF * 0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
//  3. div -7 / 2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     divu 7 / 0 -> HI/LO unchanged.
//  4. mthi A=0x1234 then mflo / mfhi (re_hi_loop 10 / 01)
//     -> hilo_out = old LO, then 0x1234.
//  5. start with req=1 -> busy stays 0, HI/LO unchanged.
//     hilowe with req=1 -> no write.
//  6. reset pulse at cycle 3 of div -> busy=0 immediately; HI=LO=0; no later write.

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// ============================================================================
// Module  : mdu_hilo_pkg
// Brief   : Shared op codes, read selects, state type and signed-divide helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_hilo_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam logic [1:0] RE_HI = 2'b01;
   localparam logic [1:0] RE_LO = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Magnitude divide then re-sign, which keeps 0x80000000 / -1 well defined.
   // Returns {remainder, quotient}.
   function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mag_a;
      logic [31:0] mag_b;
      logic [31:0] q;
      logic [31:0] r;
      mag_a = a[31] ? (~a + 32'd1) : a;
      mag_b = b[31] ? (~b + 32'd1) : b;
      q     = mag_a / mag_b;
      r     = mag_a % mag_b;
      if (a[31] ^ b[31]) q = ~q + 32'd1;
      if (a[31])         r = ~r + 32'd1;
      return {r, q};
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ============================================================================
// Module  : mdu_hilo
// Brief   : Multi-cycle multiply/divide unit with HI/LO registers and read mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hilowe,
   input  logic        hilo_A3,
   input  logic        req,
   input  logic [1:0]  re_hi_loop,
   output logic        busy,
   output logic [31:0] hilo_out
);

   localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [31:0]          r_a;
   logic [31:0]          r_b;
   logic [1:0]           r_op;
   logic [31:0]          r_hi;
   logic [31:0]          r_lo;

   logic                 w_accept;
   logic                 w_done;
   logic                 w_div_zero;
   logic [63:0]          w_prod_s;
   logic [63:0]          w_prod_u;
   logic [63:0]          w_sdiv;
   logic [31:0]          w_udiv_q;
   logic [31:0]          w_udiv_r;

   assign busy       = (r_state == ST_RUN);
   assign w_accept   = start & ~req & (r_state == ST_IDLE);
   assign w_done     = (r_state == ST_RUN) && (r_cnt == c_CNT_W'(1));
   assign w_div_zero = (r_b == 32'd0);

   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
   assign w_sdiv   = sdiv(r_a, r_b);
   assign w_udiv_q = w_div_zero ? 32'd0 : (r_a / r_b);
   assign w_udiv_r = w_div_zero ? 32'd0 : (r_a % r_b);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_done)   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operands are captured once so forwarding changes during RUN cannot leak in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_a   <= 32'd0;
         r_b   <= 32'd0;
         r_op  <= MD_MULT;
      end else if (w_accept) begin
         r_a   <= A;
         r_b   <= B;
         r_op  <= md_op;
         r_cnt <= md_op[1] ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
      end else if (busy) begin
         r_cnt <= r_cnt - c_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_done) begin
         case (r_op)
            MD_MULT:  {r_hi, r_lo} <= w_prod_s;
            MD_MULTU: {r_hi, r_lo} <= w_prod_u;
            MD_DIV:   if (!w_div_zero) {r_hi, r_lo} <= w_sdiv;
            default:  if (!w_div_zero) {r_hi, r_lo} <= {w_udiv_r, w_udiv_q};
         endcase
      end else if (hilowe && !req && !busy) begin
         if (hilo_A3) r_lo <= A;
         else         r_hi <= A;
      end
   end

   always_comb begin
      hilo_out = 32'd0;
      case (re_hi_loop)
         RE_HI:   hilo_out = r_hi;
         RE_LO:   hilo_out = r_lo;
         default: hilo_out = 32'd0;
      endcase
   end

endmodule

`default_nettype wire
